// File: rtl/rtc_hms_counter.sv
// Real-time clock core: 24 h hh:mm:ss counter driven by a prescaled tick, with
// validated load, per-field adjust, 12 h display view and a latched minute alarm.
module rtc_hms_counter #(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned INIT_H   = 0,
    parameter int unsigned INIT_M   = 0,
    parameter int unsigned INIT_S   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       set_valid,
    input  logic [5:0] set_h,
    input  logic [5:0] set_m,
    input  logic [5:0] set_s,
    output logic       set_err,
    input  logic       inc_h,
    input  logic       inc_m,
    input  logic       alarm_en,
    input  logic [5:0] alarm_h,
    input  logic [5:0] alarm_m,
    input  logic       alarm_ack,
    output logic       alarm_flag,
    output logic [5:0] horas,
    output logic [5:0] minutos,
    output logic [5:0] segundos,
    output logic [5:0] horas12,
    output logic       pm,
    output logic       sec_tick
);
    localparam int unsigned   PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(TICK_DIV - 1);

    typedef struct packed {
        logic [5:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } hms_t;

    localparam hms_t INIT_T = {6'(INIT_H), 6'(INIT_M), 6'(INIT_S)};

    hms_t          time_q, time_d, adv;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          set_err_q, set_err_d;
    logic          sec_tick_q, sec_tick_d;
    logic          alarm_q, alarm_d;
    logic          tick, set_ok;

    assign tick   = run && (pcnt_q == PCNT_MAX);
    assign set_ok = (set_h <= 6'd23) && (set_m <= 6'd59) && (set_s <= 6'd59);

    // One-second advance with full carry chain; 23:59:59 rolls to 00:00:00.
    always_comb begin
        adv = time_q;
        if (time_q.s == 6'd59) begin
            adv.s = '0;
            if (time_q.m == 6'd59) begin
                adv.m = '0;
                adv.h = (time_q.h == 6'd23) ? 6'd0 : time_q.h + 6'd1;
            end else begin
                adv.m = time_q.m + 6'd1;
            end
        end else begin
            adv.s = time_q.s + 6'd1;
        end
    end

    always_comb begin
        time_d     = time_q;
        pcnt_d     = pcnt_q;
        set_err_d  = 1'b0;
        sec_tick_d = 1'b0;
        alarm_d    = alarm_q & ~alarm_ack;

        if (run) begin
            pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        end

        if (set_valid) begin
            // A rejected load freezes the prescaler as well as the time.
            pcnt_d = pcnt_q;
            if (set_ok) begin
                time_d = {set_h, set_m, set_s};
                pcnt_d = '0;
            end else begin
                set_err_d = 1'b1;
            end
        end else if (inc_h || inc_m) begin
            if (inc_h) time_d.h = (time_q.h == 6'd23) ? 6'd0 : time_q.h + 6'd1;
            if (inc_m) time_d.m = (time_q.m == 6'd59) ? 6'd0 : time_q.m + 6'd1;
        end else if (tick) begin
            time_d     = adv;
            sec_tick_d = 1'b1;
            if (alarm_en && adv.h == alarm_h && adv.m == alarm_m && adv.s == 6'd0) begin
                alarm_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            time_q     <= INIT_T;
            pcnt_q     <= '0;
            set_err_q  <= 1'b0;
            sec_tick_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            time_q     <= time_d;
            pcnt_q     <= pcnt_d;
            set_err_q  <= set_err_d;
            sec_tick_q <= sec_tick_d;
            alarm_q    <= alarm_d;
        end
    end

    always_comb begin
        horas12 = time_q.h;
        if (time_q.h == 6'd0) begin
            horas12 = 6'd12;
        end else if (time_q.h > 6'd12) begin
            horas12 = time_q.h - 6'd12;
        end
    end

    assign pm         = (time_q.h >= 6'd12);
    assign horas      = time_q.h;
    assign minutos    = time_q.m;
    assign segundos   = time_q.s;
    assign set_err    = set_err_q;
    assign sec_tick   = sec_tick_q;
    assign alarm_flag = alarm_q;

endmodule

// File: doc/rtc_hms_counter.md
# rtc_hms_counter

Parametrised real-time clock core for the display designs. Counts hours/minutes/seconds in 24 h format from a divided system clock. Adds run/stop, a validated time load, per-field manual adjust, a 12 h display view and a latched minute alarm. Sits between the system clock and the 7-segment/BCD display driver.

## Interface
- TICK_DIV, 100_000_000: clk cycles per second; legal range ≥ 1; 1 means advance every enabled cycle.
- INIT_H, 0: hours loaded at reset (0–23).
- INIT_M, 0: minutes loaded at reset (0–59).
- INIT_S, 0: seconds loaded at reset (0–59).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- run  in  1  1 = count; 0 = hold time and prescaler.
- set_valid  in  1  load request; one-cycle pulse or level (reloads each cycle while high).
- set_h / set_m / set_s  in  6 each  time to load.
- set_err  out  1  one-cycle pulse: load rejected as out of range.
- inc_h / inc_m  in  1 each  adjust pulse: field +1 with wrap, no carry.
- alarm_en  in  1  alarm arm.
- alarm_h / alarm_m  in  6 each  alarm time (seconds implicitly 00).
- alarm_ack  in  1  clears alarm_flag.
- alarm_flag  out  1  latched alarm.
- horas / minutos / segundos  out  6 each  current time, 24 h.
- horas12  out  6  12 h view of horas (1–12).
- pm  out  1  1 when horas ≥ 12.
- sec_tick  out  1  one-cycle pulse whenever segundos advances from a prescaler tick.

## Operation
- Prescaler pcnt counts 0..TICK_DIV-1 while run=1. Internal tick = run && pcnt==TICK_DIV-1; pcnt wraps to 0 on tick. run=0 freezes pcnt.
- On tick: segundos+1; at 59, segundos→0 and minutos+1; minutos 59→0 carries to horas; horas 23→0. 23:59:59 → 00:00:00.
- Per-cycle priority: rst > set_valid > inc_h/inc_m > tick.
- Load: accepted iff set_h≤23, set_m≤59, set_s≤59. Accepted: time := inputs, pcnt := 0, tick in that cycle discarded. Rejected: time and pcnt unchanged, tick discarded, set_err=1 next cycle.
- Adjust: inc_h wraps 23→0; inc_m wraps 59→0 with no hour carry. Both may fire together. A tick coinciding with an adjust is dropped; pcnt still wraps.
- alarm_flag sets when a tick-driven advance produces horas==alarm_h, minutos==alarm_m, segundos==0 and alarm_en=1. Load and adjust never set it. Stays set until alarm_ack. Set and ack in the same cycle: set wins. alarm_en=0 does not clear an existing flag.
- 12 h view (combinational from horas): 0→12 AM; 1–11→same AM; 12→12 PM; 13–23→h−12 PM.
- Out-of-range INIT_* is a configuration error. Implementation may flag it in simulation; no runtime check.

## Timing
- Reset values, first edge with rst=1: horas=INIT_H, minutos=INIT_M, segundos=INIT_S, pcnt=0, alarm_flag=0, set_err=0, sec_tick=0. rst mid-count discards pending tick, load and adjust.
- Time, alarm_flag, set_err and sec_tick are registered. All change on the edge ending the cycle in which the cause is sampled: one cycle latency.
- After reset or an accepted load with run=1 held, the first advance is visible exactly TICK_DIV cycles later. The same spacing holds between consecutive advances.
- sec_tick is high in the same cycle the new segundos value first appears. It is not asserted for loads or adjusts.
- horas12 and pm follow horas combinationally, with zero added latency.

## Test plan
- TICK_DIV=4, INIT 23:59:58, run=1 from reset: 23:59:59 after 4 cycles, 00:00:00 after 8 cycles. sec_tick pulses on each change. pm goes 1→0 and horas12 goes 11→12.
- TICK_DIV=4: load 12:30:45 → next cycle shows 12:30:45 and pcnt=0. Load 24:00:00 → set_err pulses once and time is unchanged. Load 10:60:00 → set_err pulses once.
- TICK_DIV=1, run toggled 1,0,0,1: time advances only in cycles with run=1. A tick coinciding with inc_m leaves segundos unchanged and minutos+1. inc_m at 07:59:xx → 07:00:xx.
- Alarm 06:00, alarm_en=1, run from 05:59:58 with TICK_DIV=1: alarm_flag=1 at 06:00:00 and stays set through 06:00:05. alarm_ack clears it. Ack in the fire cycle leaves it set. Loading 06:00:00 directly does not set it.
- Reset mid-count (TICK_DIV=4, pcnt=3 with tick pending): after reset, INIT time and all flags 0. The first advance follows 4 cycles after rst falls.
- 12 h view sweep via inc_h from 0 to 23: horas12/pm give 12/0, 1/0 … 11/0, 12/1, 1/1 … 11/1. inc_h at 23 → 0.
